// File: rtl/cosine_lut_arbiter_pkg.sv
// Shared types and constants for the cosine LUT arbiter.
//   angle_t     : unsigned LUT angle in steps, N = 2^ANGLE_WIDTH_DEF steps per period
//   sample_t    : signed LUT sample
//   SINE_OFFSET : 3N/4, the phase step that turns a cosine lookup into a sine lookup
package cosine_lut_arbiter_pkg;

  localparam int unsigned FIXDT_24_WIDTH             = 24;
  localparam int unsigned CARRIER_SAMPLES_PER_PERIOD = 64;
  localparam int unsigned ANGLE_WIDTH_DEF            = $clog2(CARRIER_SAMPLES_PER_PERIOD);

  typedef logic        [ANGLE_WIDTH_DEF-1:0] angle_t;
  typedef logic signed [FIXDT_24_WIDTH-1:0]  sample_t;

  // sin(x) = cos(x - pi/2) = cos(x + 3pi/2); 3N/4 steps for an aw-bit angle.
  function automatic int unsigned sine_offset(int unsigned aw);
    return (3 * (32'd1 << aw)) / 4;
  endfunction

  localparam angle_t SINE_OFFSET = angle_t'(sine_offset(ANGLE_WIDTH_DEF));

endpackage

// File: rtl/cosine_lut_arbiter_rr.sv
// Round-robin arbiter (module rr_arbiter).
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset; pointer returns to lane NUM_REQ-1
//   req     : request vector
//   advance : a grant was accepted this cycle; only then does the pointer move
//   grant   : one-hot grant, combinational from req and the pointer
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_REQ - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] idx;
  logic            found;

  // Search starts one lane past the last winner and wraps.
  always_comb begin
    grant = '0;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = (advance && found) ? win : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PtrRst;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cosine_lut_arbiter.sv
// Shares one cosine LUT read port between NUM_REQ requesters.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-lane lookup request
//   req_angle  : per-lane angle, lane k at [k*ANGLE_WIDTH +: ANGLE_WIDTH]
//   req_sine   : per-lane select, 0 = cosine, 1 = sine
//   req_ready  : one-hot grant (combinational)
//   lut_angle  : registered LUT address
//   lut_data   : LUT output, LUT_LATENCY cycles after lut_angle
//   rsp_valid  : one-hot owner of rsp_data, LUT_LATENCY+2 cycles after the handshake
//   rsp_data   : lut_data delayed by one register
module cosine_lut_arbiter
  import cosine_lut_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = FIXDT_24_WIDTH,
  parameter int unsigned ANGLE_WIDTH   = $clog2(CARRIER_SAMPLES_PER_PERIOD),
  parameter int unsigned LUT_LATENCY   = 1,
  parameter bit          PRIORITY_REQ0 = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
  input  logic [NUM_REQ-1:0]             req_sine,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ANGLE_WIDTH-1:0]         lut_angle,
  input  logic signed [DATA_WIDTH-1:0]   lut_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic signed [DATA_WIDTH-1:0]   rsp_data
);

  localparam int unsigned LaneW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned Depth = LUT_LATENCY + 1;
  localparam logic [ANGLE_WIDTH-1:0] SineOff = ANGLE_WIDTH'(sine_offset(ANGLE_WIDTH));

  logic [NUM_REQ-1:0]     grant;
  logic                   hs;
  logic [LaneW-1:0]       sel_lane;
  logic [ANGLE_WIDTH-1:0] sel_angle;
  logic                   sel_sine;

  // Grant generation
  if (PRIORITY_REQ0) begin : g_prio
    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_grant;

    // Lane 0 is masked out of the round-robin; its pointer moves only when it actually won.
    assign rr_req = req_valid & ~NUM_REQ'(1);

    rr_arbiter #(
      .NUM_REQ (NUM_REQ)
    ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (rr_req),
      .advance (hs & ~req_valid[0]),
      .grant   (rr_grant)
    );

    assign grant = req_valid[0] ? NUM_REQ'(1) : rr_grant;
  end else begin : g_rr
    rr_arbiter #(
      .NUM_REQ (NUM_REQ)
    ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (hs),
      .grant   (grant)
    );
  end

  assign req_ready = rst ? '0 : grant;
  assign hs        = |req_ready;

  // Winner's lane index and operands
  always_comb begin
    sel_lane  = '0;
    sel_angle = '0;
    sel_sine  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_lane  = LaneW'(k);
        sel_angle = req_angle[k*ANGLE_WIDTH +: ANGLE_WIDTH];
        sel_sine  = req_sine[k];
      end
    end
  end

  // LUT address register; the add wraps modulo N by truncation.
  logic [ANGLE_WIDTH-1:0] lut_angle_q, lut_angle_d;

  always_comb begin
    lut_angle_d = lut_angle_q;
    if (hs) begin
      lut_angle_d = sel_sine ? (sel_angle + SineOff) : sel_angle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_angle_q <= '0;
    end else begin
      lut_angle_q <= lut_angle_d;
    end
  end

  assign lut_angle = lut_angle_q;

  // Tag pipeline: stage 0 aligns with lut_angle, stage Depth-1 with lut_data.
  logic [Depth-1:0] tag_vld_q;
  logic [LaneW-1:0] tag_lane_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= hs;
      for (int unsigned i = 1; i < Depth; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_lane_q[0] <= sel_lane;
    for (int unsigned i = 1; i < Depth; i++) begin
      tag_lane_q[i] <= tag_lane_q[i-1];
    end
  end

  // Response register
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic signed [DATA_WIDTH-1:0] rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
    end else if (tag_vld_q[Depth-1]) begin
      rsp_valid_q <= NUM_REQ'(1) << tag_lane_q[Depth-1];
    end else begin
      rsp_valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    rsp_data_q <= lut_data;
  end

  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cosine_lut_arbiter.sv
module tb_cosine_lut_arbiter;
  import cosine_lut_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_sine;
  logic [NR*AW-1:0] req_angle;
  logic [NR-1:0]   req_ready, rsp_valid, req_ready_p, rsp_valid_p;
  angle_t          lut_angle, lut_angle_p;
  sample_t         lut_data, rsp_data, rsp_data_p;
  sample_t         lut_mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // LUT model, one cycle read latency
  always @(posedge clk) lut_data <= lut_mem[lut_angle];

  cosine_lut_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (24),
    .ANGLE_WIDTH   (AW),
    .LUT_LATENCY   (1),
    .PRIORITY_REQ0 (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_sine  (req_sine),
    .req_ready (req_ready),
    .lut_angle (lut_angle),
    .lut_data  (lut_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  cosine_lut_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (24),
    .ANGLE_WIDTH   (AW),
    .LUT_LATENCY   (1),
    .PRIORITY_REQ0 (1'b1)
  ) dut_p (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_sine  (req_sine),
    .req_ready (req_ready_p),
    .lut_angle (lut_angle_p),
    .lut_data  (lut_data),
    .rsp_valid (rsp_valid_p),
    .rsp_data  (rsp_data_p)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_angle = '1;
    req_sine  = 4'hF;
    step();
    step();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (req_ready_p !== 4'b0000) begin
      failures++; $display("FAIL reset_ready_p got=%b exp=0000", req_ready_p);
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid);
    end
    checks++;
    if (lut_angle !== 6'd0) begin
      failures++; $display("FAIL reset_lut_angle got=%0d exp=0", lut_angle);
    end
    req_valid = '0;
    req_angle = '0;
    req_sine  = '0;
    rst       = 1'b0;
    step();
  endtask

  task automatic test_single;
    req_angle = '0;
    req_sine  = '0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    checks++;
    if (lut_angle !== 6'd0) begin
      failures++; $display("FAIL single_lut_angle got=%0d exp=0", lut_angle);
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL single_rsp_early1 got=%b exp=0000", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL single_rsp_early2 got=%b exp=0000", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0100) begin
      failures++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid);
    end
    checks++;
    if (rsp_data !== 24'sh400000) begin
      failures++; $display("FAIL single_rsp_data got=%0d exp=4194304", rsp_data);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL single_rsp_once got=%b exp=0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [NR-1:0] exp_ready, exp_rsp;
    int            lane;
    do_reset();
    for (int k = 0; k < 4; k++) req_angle[k*AW +: AW] = AW'(4*k + 1);
    req_sine = '0;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_ready = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (lut_angle !== AW'(4*((c-1) % 4) + 1)) begin
          failures++;
          $display("FAIL rr_lut_angle c=%0d got=%0d exp=%0d", c, lut_angle, 4*((c-1)%4)+1);
        end
      end
      exp_rsp = (c >= 3) ? 4'(1 << ((c-3) % 4)) : 4'h0;
      checks++;
      if (rsp_valid !== exp_rsp) begin
        failures++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp);
      end
      if (c >= 3) begin
        lane = (c - 3) % 4;
        checks++;
        if (rsp_data !== lut_mem[4*lane + 1]) begin
          failures++;
          $display("FAIL rr_rsp_data c=%0d got=%0d exp=%0d", c, rsp_data, lut_mem[4*lane+1]);
        end
      end
      step();
    end
  endtask

  task automatic test_sine_wrap;
    int      t_lane [4] = '{1, 3, 0, 2};
    int      t_ang  [4] = '{32, 4, 63, 20};
    bit      t_sin  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int      t_addr [4] = '{16, 52, 63, 4};
    sample_t exp_d;
    logic [NR-1:0] exp_oh;
    for (int i = 0; i < 4; i++) begin
      exp_oh    = 4'(1 << t_lane[i]);
      req_angle = '0;
      req_angle[t_lane[i]*AW +: AW] = AW'(t_ang[i]);
      req_sine  = t_sin[i] ? exp_oh : 4'h0;
      req_valid = exp_oh;
      #1;
      checks++;
      if (req_ready !== exp_oh) begin
        failures++; $display("FAIL sine_ready i=%0d got=%b exp=%b", i, req_ready, exp_oh);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (lut_angle !== AW'(t_addr[i])) begin
        failures++; $display("FAIL sine_lut_angle i=%0d got=%0d exp=%0d", i, lut_angle, t_addr[i]);
      end
      step();
      step();
      exp_d = (i == 0) ? 24'sd0 : lut_mem[t_addr[i]];
      checks++;
      if (rsp_valid !== exp_oh) begin
        failures++; $display("FAIL sine_rsp_valid i=%0d got=%b exp=%b", i, rsp_valid, exp_oh);
      end
      checks++;
      if (rsp_data !== exp_d) begin
        failures++; $display("FAIL sine_rsp_data i=%0d got=%0d exp=%0d", i, rsp_data, exp_d);
      end
      step();
    end
  endtask

  task automatic test_idle_gap;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL idle_first got=%b exp=0010", req_ready);
    end
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL idle_ready i=%0d got=%b exp=0000", i, req_ready);
      end
      step();
    end
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL idle_resume got=%b exp=0100", req_ready);
    end
    step();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL idle_next got=%b exp=0001", req_ready);
    end
    step();
    req_valid = '0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_midstream;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL mid_grant1 got=%b exp=0010", req_ready);
    end
    step();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL mid_grant2 got=%b exp=0001", req_ready);
    end
    step();
    rst       = 1'b1;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_ready_in_rst got=%b exp=0000", req_ready);
    end
    step();
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0000) begin
        failures++; $display("FAIL mid_flushed i=%0d got=%b exp=0000", i, rsp_valid);
      end
      step();
    end
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL mid_regrant got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    step();
    step();
    checks++;
    if (rsp_valid !== 4'b0100) begin
      failures++; $display("FAIL mid_new_rsp got=%b exp=0100", rsp_valid);
    end
    step();
  endtask

  task automatic test_priority;
    logic [NR-1:0] exp_rr;
    do_reset();
    req_sine  = '0;
    req_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready_p !== 4'b0001) begin
        failures++; $display("FAIL prio_lane0 c=%0d got=%b exp=0001", c, req_ready_p);
      end
      exp_rr = (c % 2 == 0) ? 4'b0001 : 4'b1000;
      checks++;
      if (req_ready !== exp_rr) begin
        failures++; $display("FAIL prio_rr_ref c=%0d got=%b exp=%b", c, req_ready, exp_rr);
      end
      if (c == 3) begin
        checks++;
        if (rsp_valid_p !== 4'b0001) begin
          failures++; $display("FAIL prio_rsp c=%0d got=%b exp=0001", c, rsp_valid_p);
        end
      end
      step();
    end
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready_p !== 4'b1000) begin
      failures++; $display("FAIL prio_lane3 got=%b exp=1000", req_ready_p);
    end
    step();
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready_p !== 4'b0010) begin
      failures++; $display("FAIL prio_rest_rr1 got=%b exp=0010", req_ready_p);
    end
    step();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready_p !== 4'b0100) begin
      failures++; $display("FAIL prio_rest_rr2 got=%b exp=0100", req_ready_p);
    end
    step();
    req_valid = '0;
    step();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      real v;
      v = $cos(2.0 * 3.14159265358979 * real'(k) / 64.0) * 4194304.0;
      lut_mem[k] = (v >= 0.0) ? sample_t'($rtoi(v + 0.5)) : sample_t'(-$rtoi(-v + 0.5));
    end
    rst       = 1'b1;
    req_valid = '0;
    req_angle = '0;
    req_sine  = '0;
    step();

    test_reset();
    test_single();
    test_round_robin();
    test_sine_wrap();
    test_idle_gap();
    test_reset_midstream();
    test_priority();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
